ifetch_queue: RTL and testbench

Instruction-fetch front end that owns the architectural fetch PC, issues in-order requests to instruction memory, and buffers returned words in a small FIFO feeding decode. It sits directly upstream of the next-PC logic. The head entry's PC is what the next-PC stage computes from. The next-PC result returns here as a redirect whenever the retiring instruction changes control flow.

---
 rtl/ifetch_queue.sv | 114 +++++++++++
 tb/tb_ifetch_queue.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_queue.sv
// rtl/ifetch_queue.sv - fetch PC owner, in-order imem requests and decode FIFO
module ifetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rstn,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] instr_o,
  input  logic        ready_i,
  input  logic        redirect_i,
  input  logic [31:0] npc_i
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [31:0]   fifo_pc    [DEPTH];
  logic [31:0]   fifo_instr [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop;
  logic [CW-1:0] outstanding_next;
  logic [CW:0]   occupancy;
  logic          grant;
  logic          resp;
  logic          pop;
  logic          redir;
  logic          keep;
  logic [31:0]   target;

  // Credits cover both buffered entries and in-flight requests, so a
  // returning word always finds a free FIFO slot.
  assign occupancy   = {1'b0, count} + {1'b0, outstanding};
  assign imem_req_o  = rstn && (occupancy < DEPTH_C);
  assign imem_addr_o = fetch_pc;

  assign grant  = imem_req_o && imem_gnt_i;
  // A response with nothing outstanding is a protocol error and is ignored.
  assign resp   = imem_rvalid_i && (outstanding != '0);
  assign pop    = valid_o && ready_i;
  assign redir  = pop && redirect_i;
  // Words for pre-redirect requests, including one arriving in the redirect
  // cycle itself, are thrown away.
  assign keep   = resp && (drop == '0) && !redir;
  assign target = npc_i & 32'hFFFF_FFFC;

  assign valid_o = (count != '0);
  assign pc_o    = fifo_pc[head];
  assign instr_o = fifo_instr[head];

  // In-flight count after this cycle's grant and response.
  always_comb begin
    outstanding_next = outstanding + CW'(grant) - CW'(resp);
  end

  // Control state: fetch address, pointers and the three counters.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      outstanding <= '0;
      drop        <= '0;
    end else begin
      outstanding <= outstanding_next;
      if (redir) begin
        fetch_pc <= target;
        resp_pc  <= target;
        head     <= '0;
        tail     <= '0;
        count    <= '0;
        drop     <= outstanding_next;
      end else begin
        if (grant) begin
          fetch_pc <= fetch_pc + 32'd4;
        end
        if (resp && (drop != '0)) begin
          drop <= drop - CW'(1);
        end
        if (keep) begin
          tail    <= tail + PW'(1);
          resp_pc <= resp_pc + 32'd4;
        end
        if (pop) begin
          head <= head + PW'(1);
        end
        count <= count + CW'(keep) - CW'(pop);
      end
    end
  end

  // Entry storage; the pc recorded is the address of the matching request.
  always_ff @(posedge clk) begin
    if (keep) begin
      fifo_pc[tail]    <= resp_pc;
      fifo_instr[tail] <= imem_rdata_i;
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// tb/tb_ifetch_queue.sv - randomized scoreboard bench for ifetch_queue
module tb_ifetch_queue;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        valid_o;
  logic [31:0] pc_o;
  logic [31:0] instr_o;
  logic        ready_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] npc_i = '0;

  ifetch_queue #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .valid_o(valid_o), .pc_o(pc_o), .instr_o(instr_o),
    .ready_i(ready_i), .redirect_i(redirect_i), .npc_i(npc_i)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int errors = 0;
  int pops = 0;

  // knobs, written only by the main sequence
  int gnt_pct = 100;
  int rv_pct = 100;
  int lat_min = 1;
  int lat_max = 1;
  int rdy_pct = 100;
  int redir_pct = 0;
  int force_req = 0;
  logic [31:0] force_npc = '0;

  int force_ack = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_fetch = RESET_PC;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;
  pend_t pend[$];

  function automatic logic [31:0] word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic cyc_smp();
    @(negedge clk);
    #4;
  endtask

  task automatic to_mid();
    @(negedge clk);
    #2;
  endtask

  // Instruction memory: random grants, in-order responses with random latency,
  // and an architectural model of the next address that should be requested.
  initial begin : mem
    pend_t p;
    forever begin
      @(negedge clk);
      imem_gnt_i = (int'($urandom_range(0, 99)) < gnt_pct);
      if (!rstn) begin
        pend.delete();
        exp_fetch = RESET_PC;
        imem_rvalid_i = 1'b0;
      end else begin
        imem_rvalid_i = (pend.size() != 0) && (pend[0].due <= cyc)
                        && (int'($urandom_range(0, 99)) < rv_pct);
        imem_rdata_i = imem_rvalid_i ? word(pend[0].addr) : $urandom();
      end
      #4;
      if (rstn) begin
        if (imem_req_o && imem_gnt_i) begin
          chk("grant_addr", imem_addr_o, exp_fetch);
          chk("grant_credit", 32'(pend.size() < DEPTH), 32'd1);
          p.addr = imem_addr_o;
          p.due = cyc + int'($urandom_range(lat_min, lat_max));
          pend.push_back(p);
          exp_fetch = exp_fetch + 32'd4;
        end
        if (imem_rvalid_i) void'(pend.pop_front());
        if (valid_o && ready_i && redirect_i) exp_fetch = npc_i & 32'hFFFF_FFFC;
      end
    end
  end

  // Decode driver: chooses pops and redirects, and pushes the pc each pop must see.
  initial begin : drv
    logic        rdy;
    logic        rd;
    logic [31:0] npc;
    logic [31:0] nxt_pc;
    nxt_pc = RESET_PC;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        ready_i = 1'b0;
        redirect_i = 1'b0;
        exp_q.delete();
        nxt_pc = RESET_PC;
      end else begin
        rdy = (int'($urandom_range(0, 99)) < rdy_pct);
        rd = (int'($urandom_range(0, 99)) < redir_pct);
        npc = $urandom();
        if (valid_o && rdy) begin
          if (force_ack != force_req) begin
            rd = 1'b1;
            npc = force_npc;
            force_ack = force_req;
          end
          exp_q.push_back(nxt_pc);
          nxt_pc = rd ? (npc & 32'hFFFF_FFFC) : nxt_pc + 32'd4;
        end
        ready_i = rdy;
        redirect_i = rd;
        npc_i = npc;
      end
    end
  end

  // Monitor: every consumed head is compared with the scoreboard.
  initial begin : mon
    logic [31:0] e;
    forever begin
      @(negedge clk);
      #4;
      if (rstn && valid_o && ready_i) begin
        pops++;
        if (exp_q.size() == 0) begin
          chk("pop_unexpected", pc_o, 32'hxxxx_xxxx);
        end else begin
          e = exp_q.pop_front();
          chk("head_pc", pc_o, e);
          chk("head_instr", instr_o, word(e));
        end
      end
    end
  end

  initial begin : main
    int k;
    // reset state
    repeat (3) cyc_smp();
    chk("rst_req", 32'(imem_req_o), 32'd0);
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_addr", imem_addr_o, RESET_PC);

    // release, 1-cycle memory, constant grant and ready
    to_mid();
    rstn = 1'b1;
    #2;
    chk("first_req", 32'(imem_req_o), 32'd1);
    chk("first_addr", imem_addr_o, 32'h3000);
    chk("first_valid", 32'(valid_o), 32'd0);
    cyc_smp();
    chk("second_addr", imem_addr_o, 32'h3004);
    chk("second_valid", 32'(valid_o), 32'd0);
    cyc_smp();
    chk("third_addr", imem_addr_o, 32'h3008);
    chk("valid_rise", 32'(valid_o), 32'd1);
    chk("valid_rise_pc", pc_o, 32'h3000);
    for (int i = 1; i <= 4; i++) begin
      cyc_smp();
      chk("stream_valid", 32'(valid_o), 32'd1);
      chk("stream_pc", pc_o, 32'h3000 + 32'(4 * i));
    end

    // fill with ready held low
    to_mid();
    rstn = 1'b0;
    rdy_pct = 0;
    to_mid();
    rstn = 1'b1;
    repeat (10) cyc_smp();
    chk("full_req", 32'(imem_req_o), 32'd0);
    chk("full_valid", 32'(valid_o), 32'd1);
    chk("full_head", pc_o, 32'h3000);
    rdy_pct = 100;
    repeat (8) cyc_smp();

    // redirect with requests in flight, unaligned target
    lat_min = 2;
    lat_max = 2;
    repeat (6) cyc_smp();
    force_npc = 32'h3043;
    force_req++;
    k = 0;
    while (force_ack != force_req && k < 30) begin
      cyc_smp();
      k++;
    end
    chk("redirect_taken", 32'(force_ack == force_req), 32'd1);
    cyc_smp();
    chk("redir_addr", imem_addr_o, 32'h3040);
    chk("redir_valid", 32'(valid_o), 32'd0);
    k = 0;
    while (!valid_o && k < 20) begin
      cyc_smp();
      k++;
    end
    chk("redir_head", pc_o, 32'h3040);
    repeat (6) cyc_smp();

    // grant withheld: request held stable
    gnt_pct = 0;
    repeat (4) cyc_smp();
    for (int i = 0; i < 5; i++) begin
      cyc_smp();
      chk("nogrant_req", 32'(imem_req_o), 32'd1);
      chk("nogrant_addr", imem_addr_o, exp_fetch);
    end

    // asynchronous reset mid-stream
    gnt_pct = 100;
    rdy_pct = 0;
    lat_min = 3;
    lat_max = 3;
    repeat (6) cyc_smp();
    chk("pre_reset_valid", 32'(valid_o), 32'd1);
    to_mid();
    rstn = 1'b0;
    #2;
    chk("async_valid", 32'(valid_o), 32'd0);
    chk("async_req", 32'(imem_req_o), 32'd0);
    chk("async_addr", imem_addr_o, RESET_PC);
    to_mid();
    rstn = 1'b1;
    #2;
    chk("resume_req", 32'(imem_req_o), 32'd1);
    chk("resume_addr", imem_addr_o, 32'h3000);
    chk("resume_valid", 32'(valid_o), 32'd0);

    // randomized traffic
    gnt_pct = 70;
    rv_pct = 80;
    lat_min = 1;
    lat_max = 4;
    rdy_pct = 60;
    redir_pct = 15;
    repeat (3000) cyc_smp();

    // drain
    redir_pct = 0;
    gnt_pct = 100;
    rv_pct = 100;
    rdy_pct = 100;
    repeat (30) cyc_smp();
    rdy_pct = 0;
    repeat (3) cyc_smp();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    chk("pops_seen", 32'(pops > 500), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
